// File: rtl/my_74ls161.sv
// Synchronous 4-bit-style binary counter with asynchronous clear, parallel load,
// dual count enables and a CTT-gated ripple carry, width set by WIDTH.
module my_74ls161 #(
    parameter int WIDTH = 4
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             Ld,
    input  logic             CTT,
    input  logic             CTP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             CO
);

    logic [WIDTH-1:0] q_next;

    // Load wins over count; both enables must be high to advance.
    always_comb begin
        q_next = Q;
        if (Ld) begin
            q_next = D;
        end else if (CTT && CTP) begin
            q_next = Q + WIDTH'(1);
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    // Terminal count only; CTP is deliberately excluded so carries can cascade.
    assign CO = CTT && (Q == {WIDTH{1'b1}});

endmodule

// File: tb/tb_my_74ls161.sv
// Self-checking bench for my_74ls161: directed vector table, corner sequences
// and a randomized run against an arithmetic reference model.
module tb_my_74ls161;

    localparam int W = 4;
    localparam int MODV = 1 << W;

    logic         CP;
    logic         CR;
    logic         Ld;
    logic         CTT;
    logic         CTP;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         CO;

    int checks;
    int failures;

    my_74ls161 #(.WIDTH(W)) dut (
        .CP (CP),
        .CR (CR),
        .Ld (Ld),
        .CTT(CTT),
        .CTP(CTP),
        .D  (D),
        .Q  (Q),
        .CO (CO)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct {
        logic         cr;
        logic         ld;
        logic         ctt;
        logic         ctp;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         co;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive on the falling edge, then sample just after the rising edge.
    task automatic step(input logic cr, input logic ld, input logic ctt, input logic ctp,
                        input logic [W-1:0] d);
        @(negedge CP);
        CR  = cr;
        Ld  = ld;
        CTT = ctt;
        CTP = ctp;
        D   = d;
        @(posedge CP);
        #1;
    endtask

    int model_q;
    int exp_q;
    logic r_cr, r_ld, r_ctt, r_ctp;
    logic [W-1:0] r_d;

    initial begin
        checks   = 0;
        failures = 0;
        CR  = 1'b1;
        Ld  = 1'b0;
        CTT = 1'b1;
        CTP = 1'b0;
        D   = '0;

        // Reset state: Q=0 and CO=0 even with CTT high
        #3;
        check("reset_q", 8'(Q), 8'd0);
        check("reset_co", 8'(CO), 8'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd9);
        check("reset_hold_q", 8'(Q), 8'd0);

        // Mid-cycle asynchronous clear from Q=9
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd9);
        check("load9_q", 8'(Q), 8'd9);
        @(negedge CP);
        CTT = 1'b1;
        #2;
        CR = 1'b1;
        #1;
        check("async_clear_q", 8'(Q), 8'd0);
        check("async_clear_co", 8'(CO), 8'd0);

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1101, 4'd13, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, 4'd5,  1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1101, 4'd13, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,    4'd13, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,    4'd13, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,    4'd13, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,    4'd14, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,    4'd15, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,    4'd0,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,    4'd1,  1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd15,   4'd15, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,    4'd0,  1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 4'd0,  1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 4'd7,  1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd15,   4'd15, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].cr, vecs[i].ld, vecs[i].ctt, vecs[i].ctp, vecs[i].d);
            check($sformatf("vec%0d_q", i), 8'(Q), 8'(vecs[i].q));
            check($sformatf("vec%0d_co", i), 8'(CO), 8'(vecs[i].co));
        end

        // Carry at Q=15 follows CTT combinationally, independent of CTP
        @(negedge CP);
        Ld  = 1'b0;
        CTP = 1'b0;
        CTT = 1'b1;
        #1;
        check("carry_ctt1_co", 8'(CO), 8'd1);
        CTT = 1'b0;
        #1;
        check("carry_ctt0_co", 8'(CO), 8'd0);
        @(posedge CP);
        #1;
        check("carry_hold_q", 8'(Q), 8'd15);

        // Free run from 0 for 16 edges
        @(negedge CP);
        CR = 1'b1;
        #1;
        CR  = 1'b0;
        Ld  = 1'b0;
        CTT = 1'b1;
        CTP = 1'b1;
        exp_q = 0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("run%0d_co", i), 8'(CO), 8'((exp_q == MODV - 1) ? 1 : 0));
            @(posedge CP);
            #1;
            exp_q = (exp_q + 1) % MODV;
            check($sformatf("run%0d_q", i), 8'(Q), 8'(exp_q));
        end

        // Randomized run against the reference model
        model_q = exp_q;
        for (int i = 0; i < 400; i++) begin
            r_cr  = ($urandom_range(0, 15) == 0);
            r_ld  = ($urandom_range(0, 5) == 0);
            r_ctt = ($urandom_range(0, 3) != 0);
            r_ctp = ($urandom_range(0, 3) != 0);
            r_d   = W'($urandom);
            @(negedge CP);
            CR  = r_cr;
            Ld  = r_ld;
            CTT = r_ctt;
            CTP = r_ctp;
            D   = r_d;
            if (r_cr) model_q = 0;
            #1;
            check("rnd_mid_q", 8'(Q), 8'(model_q));
            check("rnd_mid_co", 8'(CO), 8'((r_ctt && model_q == MODV - 1) ? 1 : 0));
            @(posedge CP);
            #1;
            if (r_cr)                model_q = 0;
            else if (r_ld)           model_q = int'(r_d);
            else if (r_ctt && r_ctp) model_q = (model_q + 1) % MODV;
            check("rnd_q", 8'(Q), 8'(model_q));
            check("rnd_co", 8'(CO), 8'((r_ctt && model_q == MODV - 1) ? 1 : 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
